// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared register map, CTRL bit layout and widths for key_sw_io
package io_pkg;

  localparam int KEY_W = 4;
  localparam int SW_W  = 10;

  localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
  localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
  localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 8;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic ready;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    logic [31:0] w;
    w              = '0;
    w[READY_BIT]   = c.ready;
    w[OVERRUN_BIT] = c.ovr;
    w[IE_BIT]      = c.ie;
    return w;
  endfunction

  // A capture beats both a same-cycle read-clear of Ready and a store clearing Overrun.
  function automatic ctrl_t ctrl_next(ctrl_t c, logic cap, logic rd, logic wr, logic [31:0] wd);
    ctrl_t n;
    n = c;
    if (wr) begin
      n.ie = wd[IE_BIT];
      if (!wd[OVERRUN_BIT]) n.ovr = 1'b0;
    end
    if (rd) n.ready = 1'b0;
    if (cap) begin
      if (c.ready && !rd) n.ovr = 1'b1;
      n.ready = 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/key_sw_io_if.sv
// rtl/key_sw_io_if.sv - CPU data-bus port of the KEY/SW responder
interface key_sw_io_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        hit;
  logic        intr;

  modport master (output addr, wdata, we, re, input rdata, hit, intr);
  modport slave  (input addr, wdata, we, re, output rdata, hit, intr);
endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - candidate register and stability counter that strobe a switch commit
module sw_debounce #(
  parameter int W               = 10,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_sync,
  input  logic [W-1:0] committed,
  output logic         commit,
  output logic [W-1:0] cand
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sw_sync != cand_q) begin
      cand_d = sw_sync;
      cnt_d  = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Commit on the edge the count reaches its last value, so SDATA lands exactly DEBOUNCE_CYCLES after sync.
  assign commit = (sw_sync == cand_q) && (cnt_d == LAST) && (cand_q != committed);
  assign cand   = cand_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/key_sw_io.sv
// rtl/key_sw_io.sv - KEY/SW memory-mapped responder; KEY_SW_IO_DEBOUNCE_EN enables switch debounce
module key_sw_io
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] KEY,
  input  logic [SW_W-1:0]  SW,
  key_sw_io_if.slave       bus
);

  logic [KEY_W-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d, kdata_q, kdata_d;
  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sdata_q, sdata_d;
  ctrl_t            kctrl_q, kctrl_d, sctrl_q, sctrl_d;

  logic             k_rd, s_rd, k_wr, s_wr, k_cap, s_cap;
  logic [SW_W-1:0]  s_new;

`ifdef KEY_SW_IO_DEBOUNCE_EN
  sw_debounce #(
    .W              (SW_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_debounce (
    .clk      (clk),
    .reset    (reset),
    .sw_sync  (sw_s2_q),
    .committed(sdata_q),
    .commit   (s_cap),
    .cand     (s_new)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0) ^ (CNT_W > 0);
  assign s_new      = sw_s2_q;
  assign s_cap      = (sw_s2_q != sdata_q);
`endif

  assign k_rd  = bus.re && (bus.addr == KDATA_ADDR);
  assign s_rd  = bus.re && (bus.addr == SDATA_ADDR);
  assign k_wr  = bus.we && (bus.addr == KCTRL_ADDR);
  assign s_wr  = bus.we && (bus.addr == SCTRL_ADDR);
  assign k_cap = (key_s2_q != kdata_q);

  always_comb begin
    key_s1_d = ~KEY;
    key_s2_d = key_s1_q;
    sw_s1_d  = SW;
    sw_s2_d  = sw_s1_q;
    kdata_d  = k_cap ? key_s2_q : kdata_q;
    sdata_d  = s_cap ? s_new : sdata_q;
    kctrl_d  = ctrl_next(kctrl_q, k_cap, k_rd, k_wr, bus.wdata);
    sctrl_d  = ctrl_next(sctrl_q, s_cap, s_rd, s_wr, bus.wdata);
  end

  always_comb begin
    bus.rdata = '0;
    bus.hit   = 1'b1;
    case (bus.addr)
      KDATA_ADDR: bus.rdata = {{(32-KEY_W){1'b0}}, kdata_q};
      SDATA_ADDR: bus.rdata = {{(32-SW_W){1'b0}}, sdata_q};
      KCTRL_ADDR: bus.rdata = ctrl_word(kctrl_q);
      SCTRL_ADDR: bus.rdata = ctrl_word(sctrl_q);
      default:    bus.hit   = 1'b0;
    endcase
  end

  assign bus.intr = (kctrl_q.ie && kctrl_q.ready) || (sctrl_q.ie && sctrl_q.ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      kdata_q  <= '0;
      sdata_q  <= '0;
      kctrl_q  <= '0;
      sctrl_q  <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      kdata_q  <= kdata_d;
      sdata_q  <= sdata_d;
      kctrl_q  <= kctrl_d;
      sctrl_q  <= sctrl_d;
    end
  end

endmodule
